// File: rtl/req_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module   : req_encoder_8to3
// Brief    : Sequential 8-to-3 encoder; emits the index of each set request bit
//            one per valid/ready handshake.
// Revision : 1.0
// ============================================================================
module req_encoder_8to3 #(
  parameter int HIGH_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_addr,
  output logic       out_last,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;

  logic [1:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] sel_w;
  logic       single_w;
  logic       serve_w;

  // The loop direction makes the preferred end of the vector win the last write.
  always_comb begin
    sel_w = '0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) sel_w = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) sel_w = 3'(i);
      end
    end
  end

  assign single_w  = (pending_q != 8'd0) && ((pending_q & (pending_q - 8'd1)) == 8'd0);
  assign serve_w   = (state_q == ST_SERVE);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = serve_w;
  assign busy      = serve_w;
  assign out_addr  = serve_w ? sel_w : 3'd0;
  assign out_last  = serve_w & single_w;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && (in_req != 8'd0)) begin
          pending_d = in_req;
          state_d   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (pending_q == 8'd0) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          if (single_w) begin
            pending_d = 8'd0;
            state_d   = ST_IDLE;
          end else begin
            pending_d = pending_q & ~(8'd1 << sel_w);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_req_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_encoder_8to3
// Brief    : Scoreboard bench driving both service orders from one stimulus.
// Revision : 1.0
// ============================================================================
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_req;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_last0, busy0;
  logic [2:0] out_addr0;
  logic       in_ready1, out_valid1, out_last1, busy1;
  logic [2:0] out_addr1;

  int n_vec = 0;
  int n_err = 0;

  // Expected entries are {last, addr}.
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  req_encoder_8to3 #(.HIGH_FIRST(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_req(in_req), .out_valid(out_valid0), .out_ready(out_ready),
    .out_addr(out_addr0), .out_last(out_last0), .busy(busy0)
  );

  req_encoder_8to3 #(.HIGH_FIRST(1)) u_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_req(in_req), .out_valid(out_valid1), .out_ready(out_ready),
    .out_addr(out_addr1), .out_last(out_last1), .busy(busy1)
  );

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: list the set indices, then hand them out in each service order.
  function automatic void push_exp(input logic [7:0] v);
    int idx[$];
    int n;
    for (int i = 0; i < 8; i++) if (v[i]) idx.push_back(i);
    n = idx.size();
    for (int k = 0; k < n; k++) begin
      q0.push_back({(k == n - 1), 3'(idx[k])});
      q1.push_back({(k == n - 1), 3'(idx[n - 1 - k])});
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready0", int'(in_ready0), 1);
      chk("rst_out_valid0", int'(out_valid0), 0);
      chk("rst_out_addr0", int'(out_addr0), 0);
      chk("rst_busy0", int'(busy0), 0);
    end else if (q0.size() != 0) begin
      chk("out_valid0", int'(out_valid0), 1);
      chk("busy0", int'(busy0), 1);
      chk("in_ready0", int'(in_ready0), 0);
      chk("out_addr0", int'(out_addr0), int'(q0[0][2:0]));
      chk("out_last0", int'(out_last0), int'(q0[0][3]));
      if (out_ready) void'(q0.pop_front());
    end else begin
      chk("idle_out_valid0", int'(out_valid0), 0);
      chk("idle_in_ready0", int'(in_ready0), 1);
      chk("idle_out_addr0", int'(out_addr0), 0);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready1", int'(in_ready1), 1);
      chk("rst_out_valid1", int'(out_valid1), 0);
      chk("rst_out_addr1", int'(out_addr1), 0);
      chk("rst_busy1", int'(busy1), 0);
    end else if (q1.size() != 0) begin
      chk("out_valid1", int'(out_valid1), 1);
      chk("busy1", int'(busy1), 1);
      chk("in_ready1", int'(in_ready1), 0);
      chk("out_addr1", int'(out_addr1), int'(q1[0][2:0]));
      chk("out_last1", int'(out_last1), int'(q1[0][3]));
      if (out_ready) void'(q1.pop_front());
    end else begin
      chk("idle_out_valid1", int'(out_valid1), 0);
      chk("idle_in_ready1", int'(in_ready1), 1);
      chk("idle_out_addr1", int'(out_addr1), 0);
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [7:0] v);
    int t = 0;
    while (!in_ready0 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 100) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_req   = v;
    @(posedge clk);
    if (v != 8'd0) push_exp(v);
    #2;
    in_valid = 1'b0;
    in_req   = 8'($urandom);
  endtask

  task automatic drain(input bit rand_ready);
    int t = 0;
    while (!(in_ready0 && q0.size() == 0) && t < 200) begin
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk); #2;
      t++;
    end
    if (t >= 200) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_req    = 8'hFF;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    push_exp(8'hFF);
    #2;
    in_valid = 1'b0;
    drain(1'b0);

    send(8'b0010_0000);
    drain(1'b0);
    send(8'b1000_1011);
    drain(1'b0);

    // Backpressure, with SERVE-time input changes that must be ignored.
    out_ready = 1'b0;
    send(8'b0000_0110);
    in_valid = 1'b1;
    repeat (3) begin
      in_req = 8'($urandom);
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(1'b0);

    send(8'h00);
    repeat (2) @(posedge clk);
    #2;
    send(8'h01);
    drain(1'b0);

    // Reset in the middle of servicing 8'hF0.
    send(8'hF0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("async_drop0", int'(out_valid0), 0);
    chk("async_drop1", int'(out_valid1), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(8'h02);
    drain(1'b0);

    repeat (60) begin
      v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      send(v);
      drain(1'b1);
    end

    out_ready = 1'b1;
    drain(1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
